// File: rtl/dtmf_tone_generator.sv
// DTMF transmitter. It latches a key code and produces a row+column dual-tone burst
// followed by a silent gap, one signed 16-bit PCM sample per sample-rate strobe.
module dtmf_tone_generator #(
  parameter int unsigned TONE_SAMPLES = 400,
  parameter int unsigned GAP_SAMPLES  = 400
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        start,
  input  logic [3:0]  key,
  output logic        busy,
  output logic [15:0] sample_out,
  output logic        sample_valid,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

  localparam logic [15:0] TONE_LAST = 16'(TONE_SAMPLES - 1);
  localparam logic [15:0] GAP_LAST  = 16'((GAP_SAMPLES == 0) ? 0 : GAP_SAMPLES - 1);
  localparam bit          HAS_GAP   = (GAP_SAMPLES != 0);

  localparam logic [15:0] ROW_WORDS [4] = '{16'd5710, 16'd6308, 16'd6980, 16'd7709};
  localparam logic [15:0] COL_WORDS [4] = '{16'd9904, 16'd10945, 16'd12100, 16'd13378};

  // First quadrant of round(127*sin(2*pi*i/256)), i = 0..64; the other three follow by symmetry.
  localparam logic [7:0] QUARTER [0:64] = '{
    8'd0,   8'd3,   8'd6,   8'd9,   8'd12,  8'd16,  8'd19,  8'd22,
    8'd25,  8'd28,  8'd31,  8'd34,  8'd37,  8'd40,  8'd43,  8'd46,
    8'd49,  8'd51,  8'd54,  8'd57,  8'd60,  8'd63,  8'd65,  8'd68,
    8'd71,  8'd73,  8'd76,  8'd78,  8'd81,  8'd83,  8'd85,  8'd88,
    8'd90,  8'd92,  8'd94,  8'd96,  8'd98,  8'd100, 8'd102, 8'd104,
    8'd106, 8'd107, 8'd109, 8'd111, 8'd112, 8'd113, 8'd115, 8'd116,
    8'd117, 8'd118, 8'd120, 8'd121, 8'd122, 8'd122, 8'd123, 8'd124,
    8'd125, 8'd125, 8'd126, 8'd126, 8'd126, 8'd127, 8'd127, 8'd127,
    8'd127
  };

  state_t      state_reg, state_next;
  logic [3:0]  key_reg, key_next;
  logic [15:0] count_reg, count_next;
  logic [15:0] sample_reg, sample_next;
  logic        valid_reg, valid_next;
  logic        done_reg, done_next;
  logic        accept, tone_step;

  logic [1:0]  row_sel, col_sel;
  logic [15:0] row_word, col_word;
  logic [7:0]  lut_val [2];
  logic [8:0]  tone_sum;
  logic [15:0] tone_sample;

  // Keypad position of each code: row is the low-group tone, column the high-group tone.
  always_comb begin
    row_sel = 2'd0;
    col_sel = 2'd0;
    case (key_reg)
      4'h1: begin row_sel = 2'd0; col_sel = 2'd0; end
      4'h2: begin row_sel = 2'd0; col_sel = 2'd1; end
      4'h3: begin row_sel = 2'd0; col_sel = 2'd2; end
      4'hA: begin row_sel = 2'd0; col_sel = 2'd3; end
      4'h4: begin row_sel = 2'd1; col_sel = 2'd0; end
      4'h5: begin row_sel = 2'd1; col_sel = 2'd1; end
      4'h6: begin row_sel = 2'd1; col_sel = 2'd2; end
      4'hB: begin row_sel = 2'd1; col_sel = 2'd3; end
      4'h7: begin row_sel = 2'd2; col_sel = 2'd0; end
      4'h8: begin row_sel = 2'd2; col_sel = 2'd1; end
      4'h9: begin row_sel = 2'd2; col_sel = 2'd2; end
      4'hC: begin row_sel = 2'd2; col_sel = 2'd3; end
      4'hE: begin row_sel = 2'd3; col_sel = 2'd0; end
      4'h0: begin row_sel = 2'd3; col_sel = 2'd1; end
      4'hF: begin row_sel = 2'd3; col_sel = 2'd2; end
      4'hD: begin row_sel = 2'd3; col_sel = 2'd3; end
      default: begin row_sel = 2'd0; col_sel = 2'd0; end
    endcase
  end

  assign row_word = ROW_WORDS[row_sel];
  assign col_word = COL_WORDS[col_sel];

  // Channel 0 is the row tone, channel 1 the column tone.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_tone
      logic [15:0] phase_reg, phase_next, inc;
      logic [6:0]  q_idx;
      logic [7:0]  mag;

      assign inc = (gi == 0) ? row_word : col_word;

      always_comb begin
        phase_next = phase_reg;
        if (accept)
          phase_next = '0;
        else if (tone_step)
          phase_next = phase_reg + inc;
      end

      always_ff @(posedge clock) begin
        if (reset)
          phase_reg <= '0;
        else
          phase_reg <= phase_next;
      end

      assign q_idx       = phase_reg[14] ? (7'd64 - {1'b0, phase_reg[13:8]}) : {1'b0, phase_reg[13:8]};
      assign mag         = QUARTER[q_idx];
      assign lut_val[gi] = phase_reg[15] ? (8'd0 - mag) : mag;
    end
  endgenerate

  assign tone_sum    = {lut_val[0][7], lut_val[0]} + {lut_val[1][7], lut_val[1]};
  assign tone_sample = {tone_sum[8], tone_sum, 6'd0};

  assign accept    = (state_reg == IDLE) && start;
  assign tone_step = (state_reg == TONE) && enable;

  always_comb begin
    state_next  = state_reg;
    key_next    = key_reg;
    count_next  = count_reg;
    sample_next = sample_reg;
    valid_next  = 1'b0;
    done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = TONE;
          key_next   = key;
          count_next = '0;
        end
      end
      TONE: begin
        if (enable) begin
          valid_next  = 1'b1;
          sample_next = tone_sample;
          count_next  = count_reg + 16'd1;
          if (count_reg == TONE_LAST) begin
            count_next = '0;
            if (HAS_GAP) begin
              state_next = GAP;
            end else begin
              state_next = IDLE;
              done_next  = 1'b1;
            end
          end
        end
      end
      GAP: begin
        if (enable) begin
          valid_next  = 1'b1;
          sample_next = '0;
          count_next  = count_reg + 16'd1;
          if (count_reg == GAP_LAST) begin
            count_next = '0;
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      key_reg    <= '0;
      count_reg  <= '0;
      sample_reg <= '0;
      valid_reg  <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      key_reg    <= key_next;
      count_reg  <= count_next;
      sample_reg <= sample_next;
      valid_reg  <= valid_next;
      done_reg   <= done_next;
    end
  end

  // Leaving TONE/GAP for IDLE drops busy on the same edge that raises the final valid.
  assign busy         = (state_reg != IDLE);
  assign sample_out   = sample_reg;
  assign sample_valid = valid_reg;
  assign done         = done_reg;

endmodule

// File: tb/tb_dtmf_tone_generator.sv
// Scoreboard bench for dtmf_tone_generator: three instances with different burst/gap
// lengths share one clock/reset; a bench-side sine model predicts every sample.
module tb_dtmf_tone_generator;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        en [3];
  logic        st [3];
  logic [3:0]  ky [3];
  logic        bz [3];
  logic        vl [3];
  logic        dn [3];
  logic [15:0] so [3];

  dtmf_tone_generator #(.TONE_SAMPLES(4), .GAP_SAMPLES(2)) u_a (
    .clock(clock), .reset(reset), .enable(en[0]), .start(st[0]), .key(ky[0]),
    .busy(bz[0]), .sample_out(so[0]), .sample_valid(vl[0]), .done(dn[0]));

  dtmf_tone_generator #(.TONE_SAMPLES(400), .GAP_SAMPLES(400)) u_b (
    .clock(clock), .reset(reset), .enable(en[1]), .start(st[1]), .key(ky[1]),
    .busy(bz[1]), .sample_out(so[1]), .sample_valid(vl[1]), .done(dn[1]));

  dtmf_tone_generator #(.TONE_SAMPLES(4), .GAP_SAMPLES(0)) u_c (
    .clock(clock), .reset(reset), .enable(en[2]), .start(st[2]), .key(ky[2]),
    .busy(bz[2]), .sample_out(so[2]), .sample_valid(vl[2]), .done(dn[2]));

  typedef struct {
    int inst;
    int smp;
    bit last;
  } exp_t;

  exp_t  sb [$];
  exp_t  mon_e;
  int    obs_log [$];
  int    lut [256];
  int    row_w [4] = '{5710, 6308, 6980, 7709};
  int    col_w [4] = '{9904, 10945, 12100, 13378};
  string grid = "123A456B789C*0#D";
  string codes = "0123456789ABCD*#";
  int    total = 0;
  int    bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void key_words(input int k, output int wl, output int wh);
    byte c;
    c  = codes[k];
    wl = 0;
    wh = 0;
    for (int p = 0; p < 16; p++) begin
      if (grid[p] == c) begin
        wl = row_w[p / 4];
        wh = col_w[p % 4];
      end
    end
  endfunction

  task automatic push_burst(input int i, input int k, input int nt, input int ng);
    logic [15:0] pl, ph;
    int wl, wh;
    exp_t e;
    key_words(k, wl, wh);
    pl = '0;
    ph = '0;
    for (int n = 0; n < nt; n++) begin
      e.inst = i;
      e.smp  = (lut[pl[15:8]] + lut[ph[15:8]]) * 64;
      e.last = (ng == 0) && (n == nt - 1);
      sb.push_back(e);
      pl = pl + 16'(wl);
      ph = ph + 16'(wh);
    end
    for (int n = 0; n < ng; n++) begin
      e.inst = i;
      e.smp  = 0;
      e.last = (n == ng - 1);
      sb.push_back(e);
    end
  endtask

  // Drives the enable pattern until done, optionally poking a competing start mid-burst.
  task automatic wait_done(input int i, input int period, input int budget,
                           input int poke_cyc, input int poke_key);
    int cyc;
    bit seen;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < budget) begin
      en[i] = ((cyc % period) == 0);
      st[i] = (cyc == poke_cyc);
      if (cyc == poke_cyc) ky[i] = 4'(poke_key);
      @(negedge clock);
      cyc++;
      if (dn[i] === 1'b1) seen = 1'b1;
    end
    en[i] = 1'b0;
    st[i] = 1'b0;
    #1;
    chk("done_seen", int'(seen), 1);
    chk("sb_empty", sb.size(), 0);
    chk("busy_low", int'(bz[i]), 0);
  endtask

  task automatic run(input int i, input int k, input int nt, input int ng,
                     input int period, input int budget, input int poke_cyc, input int poke_key);
    push_burst(i, k, nt, ng);
    @(negedge clock);
    ky[i] = 4'(k);
    st[i] = 1'b1;
    @(negedge clock);
    st[i] = 1'b0;
    chk("busy_after_start", int'(bz[i]), 1);
    wait_done(i, period, budget, poke_cyc, poke_key);
  endtask

  // Monitor: every valid pops one expected sample; done/busy must mark only the final one.
  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (vl[i] === 1'b1) begin
        obs_log.push_back(int'($signed(so[i])));
        if (sb.size() == 0) begin
          chk("extra_valid", i, -1);
        end else begin
          mon_e = sb.pop_front();
          chk("inst", i, mon_e.inst);
          chk("sample", int'($signed(so[i])), mon_e.smp);
          chk("done_flag", int'(dn[i]), int'(mon_e.last));
          chk("busy_flag", int'(bz[i]), int'(!mon_e.last));
        end
      end else if (dn[i] === 1'b1) begin
        chk("stray_done", i, -1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    real r;
    for (int i = 0; i < 256; i++) begin
      r = 127.0 * $sin(2.0 * 3.14159265358979 * i / 256.0);
      lut[i] = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    end
    for (int i = 0; i < 3; i++) begin
      en[i] = 1'b0;
      st[i] = 1'b0;
      ky[i] = 4'h0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", int'(bz[i]), 0);
      chk("rst_sample", int'(so[i]), 0);
      chk("rst_valid", int'(vl[i]), 0);
      chk("rst_done", int'(dn[i]), 0);
    end
    reset = 1'b0;

    // Key 5, 4+2 samples, enable every 4 cycles; first two samples are known by hand.
    obs_log.delete();
    run(0, 5, 4, 2, 4, 200, -1, 0);
    chk("k5_s0", (obs_log.size() > 0) ? obs_log[0] : -99999, 0);
    chk("k5_s1", (obs_log.size() > 1) ? obs_log[1] : -99999, 11520);
    chk("k5_count", obs_log.size(), 6);

    // Competing start with another key in the middle of the tone is ignored.
    run(0, 5, 4, 2, 4, 200, 5, 9);
    repeat (10) begin
      en[0] = 1'b1;
      @(negedge clock);
    end
    en[0] = 1'b0;

    // Reset in mid-tone, then a fresh burst restarts from phase zero.
    push_burst(0, 7, 4, 2);
    @(negedge clock);
    ky[0] = 4'h7;
    st[0] = 1'b1;
    @(negedge clock);
    st[0] = 1'b0;
    en[0] = 1'b1;
    @(negedge clock);
    en[0] = 1'b0;
    @(negedge clock);
    en[0] = 1'b1;
    @(negedge clock);
    en[0] = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    sb.delete();
    chk("midrst_busy", int'(bz[0]), 0);
    chk("midrst_sample", int'(so[0]), 0);
    chk("midrst_valid", int'(vl[0]), 0);
    run(0, 7, 4, 2, 2, 200, -1, 0);

    // No gap: done on the last tone sample, then immediate restart with '#'.
    run(2, 13, 4, 0, 3, 200, -1, 0);
    run(2, 15, 4, 0, 1, 200, -1, 0);

    // Long burst with continuous enable: phases wrap many times.
    run(1, 1, 400, 400, 1, 2000, -1, 0);

    // Every key, compared sample-by-sample against the model's tuning words.
    for (int k = 0; k < 16; k++) begin
      run(0, k, 4, 2, 1 + (k % 2), 200, -1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
